// File: rtl/wc_pin_bridge_if.sv
// ---------------------------------------------------------------------------
// wc_pin_bridge_if
// Bundles the signals between the pad ring, the Winograd core and the
// pin bridge.
//   slave  modport : bridge side (receives pad beats and core results,
//                    drives core words, pad beats and status)
//   master modport : pad/core side, the mirror image of slave
// Signals:
//   pin_d/pin_d_vld        narrow input beat from pads
//   loopback               quasi-static loopback select
//   core_d/core_d_vld      assembled word to core, one-cycle strobe
//   core_z/core_z_vld      core result word offered to the output FIFO
//   core_z_rdy             output FIFO can take core_z
//   pin_z/pin_z_vld        narrow output beat to pads
//   lb_ovf                 sticky loopback-overflow flag
// ---------------------------------------------------------------------------
interface wc_pin_bridge_if #(
    parameter int PIN_W      = 10,
    parameter int CORE_IN_W  = 40,
    parameter int CORE_OUT_W = 40
);
    logic [PIN_W-1:0]      pin_d;
    logic                  pin_d_vld;
    logic                  loopback;
    logic [CORE_IN_W-1:0]  core_d;
    logic                  core_d_vld;
    logic [CORE_OUT_W-1:0] core_z;
    logic                  core_z_vld;
    logic                  core_z_rdy;
    logic [PIN_W-1:0]      pin_z;
    logic                  pin_z_vld;
    logic                  lb_ovf;

    modport slave (
        input  pin_d, pin_d_vld, loopback, core_z, core_z_vld,
        output core_d, core_d_vld, core_z_rdy, pin_z, pin_z_vld, lb_ovf
    );

    modport master (
        output pin_d, pin_d_vld, loopback, core_z, core_z_vld,
        input  core_d, core_d_vld, core_z_rdy, pin_z, pin_z_vld, lb_ovf
    );
endinterface

// File: rtl/wc_pin_bridge.sv
// ---------------------------------------------------------------------------
// wc_pin_bridge
// Pin-side bridge for the Winograd convolution core. Narrow pad beats are
// assembled into full-width core input words (first beat in the LSBs);
// full-width core result words are queued in a small FIFO and serialised
// back onto the narrow output pads, LSB beat first. In loopback mode the
// assembled words go straight into the output FIFO instead of the core.
// Ports:
//   clk   single clock
//   rst   asynchronous active-high reset
//   bus   wc_pin_bridge_if.slave (pad beats, core words, status)
// ---------------------------------------------------------------------------
module wc_pin_bridge #(
    parameter int PIN_W      = 10,
    parameter int CORE_IN_W  = 40,
    parameter int CORE_OUT_W = 40,
    parameter int OUT_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    wc_pin_bridge_if.slave bus
);
    localparam int IN_BEATS  = CORE_IN_W / PIN_W;
    localparam int OUT_BEATS = CORE_OUT_W / PIN_W;
    localparam int IC_W      = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OC_W      = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int AW        = $clog2(OUT_DEPTH);
    // Loopback only makes sense when an assembled word fits a FIFO entry.
    localparam bit LB_OK     = (CORE_IN_W == CORE_OUT_W);

    localparam logic [IC_W-1:0] IN_LAST = IC_W'(IN_BEATS - 1);
    localparam logic [IC_W-1:0] IC_ONE  = IC_W'(1);
    localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_BEATS - 1);
    localparam logic [OC_W-1:0] OC_ONE  = OC_W'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [AW:0]     CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(OUT_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    // ------------------------------------------------------------------
    // Input assembler
    // ------------------------------------------------------------------
    logic [IC_W-1:0]      in_cnt_q, in_cnt_d;
    logic [CORE_IN_W-1:0] asm_q, asm_word;
    logic [CORE_IN_W-1:0] core_d_q, core_d_d;
    logic                 core_d_vld_q, core_d_vld_d;
    logic                 in_last, lb_mode, lb_push;

    assign lb_mode = LB_OK & bus.loopback;
    assign in_last = bus.pin_d_vld && (in_cnt_q == IN_LAST);
    assign lb_push = in_last && lb_mode;

    // Current partial word with the incoming beat merged in, so the last
    // beat can be issued in the same edge it is sampled.
    always_comb begin
        asm_word = asm_q;
        for (int k = 0; k < IN_BEATS; k++) begin
            if (in_cnt_q == IC_W'(k)) begin
                asm_word[k*PIN_W +: PIN_W] = bus.pin_d;
            end
        end
    end

    always_comb begin
        in_cnt_d     = in_cnt_q;
        core_d_d     = core_d_q;
        core_d_vld_d = 1'b0;
        if (bus.pin_d_vld) begin
            in_cnt_d = in_last ? '0 : (in_cnt_q + IC_ONE);
        end
        if (in_last && !lb_mode) begin
            core_d_d     = asm_word;
            core_d_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q     <= '0;
            core_d_q     <= '0;
            core_d_vld_q <= 1'b0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            core_d_q     <= core_d_d;
            core_d_vld_q <= core_d_vld_d;
        end
    end

    // Partial-word storage needs no reset: every beat position is rewritten
    // before the counter can reach the last beat again.
    always_ff @(posedge clk) begin
        if (bus.pin_d_vld) begin
            asm_q <= asm_word;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [CORE_OUT_W-1:0] mem_q [OUT_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  full, empty, z_rdy, core_push, push, pop;
    logic                  lb_ovf_q, lb_ovf_d;
    logic [CORE_OUT_W-1:0] push_word, head;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    // Derived from the registered count: a pop frees its slot next cycle.
    assign z_rdy     = !full && !lb_mode;
    assign core_push = bus.core_z_vld && z_rdy;
    assign push      = core_push || (lb_push && !full);
    assign push_word = lb_mode ? CORE_OUT_W'(asm_word) : bus.core_z;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        lb_ovf_d = lb_ovf_q || (lb_push && full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lb_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lb_ovf_q <= lb_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // ------------------------------------------------------------------
    // Output serialiser
    // ------------------------------------------------------------------
    logic [0:0]            state_q, state_d;
    logic [OC_W-1:0]       beat_q, beat_d;
    logic [PIN_W-1:0]      pin_z_q, pin_z_d;
    logic [CORE_OUT_W-1:0] sh_q, sh_d;

    // Pop when idle, or on the last beat so the next word follows gaplessly.
    assign pop = !empty && ((state_q == S_IDLE) || (beat_q == OUT_LAST));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pin_z_d = pin_z_q;
        sh_d    = sh_q;
        if (pop) begin
            state_d = S_SEND;
            beat_d  = '0;
            pin_z_d = head[PIN_W-1:0];
            sh_d    = head >> PIN_W;
        end else if (state_q == S_SEND) begin
            if (beat_q == OUT_LAST) begin
                state_d = S_IDLE;
                pin_z_d = '0;
            end else begin
                beat_d  = beat_q + OC_ONE;
                pin_z_d = sh_q[PIN_W-1:0];
                sh_d    = sh_q >> PIN_W;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            pin_z_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pin_z_q <= pin_z_d;
        end
    end

    // Remaining beats of the word in flight; only read while in SEND.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign bus.core_d     = core_d_q;
    assign bus.core_d_vld = core_d_vld_q;
    assign bus.core_z_rdy = z_rdy;
    assign bus.pin_z      = pin_z_q;
    assign bus.pin_z_vld  = (state_q == S_SEND);
    assign bus.lb_ovf     = lb_ovf_q;
endmodule

// File: tb/tb_wc_pin_bridge.sv
// ---------------------------------------------------------------------------
// tb_wc_pin_bridge
// Directed bench for wc_pin_bridge with PIN_W=10, 40-bit words, 4-deep FIFO.
// ---------------------------------------------------------------------------
module tb_wc_pin_bridge;
    localparam int PW    = 10;
    localparam int CW    = 40;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    wc_pin_bridge_if #(.PIN_W(PW), .CORE_IN_W(CW), .CORE_OUT_W(CW)) bus();

    wc_pin_bridge #(
        .PIN_W(PW), .CORE_IN_W(CW), .CORE_OUT_W(CW), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cw(input int k);
        return {8'hC0 + 8'(k), 16'h5AA5, 16'(k * 257 + 3)};
    endfunction

    function automatic logic [CW-1:0] lbw(input int k);
        return {10'h3F0 + 10'(k), 10'h155, 10'h2AA, 10'h00F + 10'(k)};
    endfunction

    // ------------------------------------------------------------------
    // Output monitor: rebuilds words from pin_z beats
    // ------------------------------------------------------------------
    int            mon_cyc = 0;
    int            mon_beats, mon_first, mon_last, mon_bi, mon_dvld;
    logic [CW-1:0] mon_acc;
    logic [CW-1:0] mon_words[$];
    logic [CW-1:0] expq[$];

    task automatic mon_clear();
        mon_beats = 0;
        mon_first = -1;
        mon_last  = -1;
        mon_bi    = 0;
        mon_dvld  = 0;
        mon_acc   = '0;
        mon_words.delete();
    endtask

    always @(negedge clk) begin
        mon_cyc++;
        if (bus.pin_z_vld) begin
            mon_acc[mon_bi*PW +: PW] = bus.pin_z;
            mon_bi++;
            mon_beats++;
            if (mon_first < 0) mon_first = mon_cyc;
            mon_last = mon_cyc;
            if (mon_bi == CW / PW) begin
                mon_words.push_back(mon_acc);
                mon_bi = 0;
            end
        end else begin
            check("pin_z_idle_zero", 64'(bus.pin_z), 64'h0);
        end
        if (bus.core_d_vld) mon_dvld++;
    end

    task automatic check_stream(input string tag);
        int n;
        n = expq.size();
        check({tag, "_nwords"}, 64'(mon_words.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            if (k < mon_words.size())
                check($sformatf("%s_word%0d", tag, k), 64'(mon_words[k]), 64'(expq[k]));
        end
        check({tag, "_beats"}, 64'(mon_beats), 64'(n * 4));
        check({tag, "_contig"}, 64'(mon_last - mon_first + 1), 64'(n * 4));
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [PW-1:0] pd;
        logic          pdv;
        logic [CW-1:0] cz;
        logic          czv;
        logic          e_dv;
        logic [CW-1:0] e_d;
        logic          e_zv;
        logic [PW-1:0] e_z;
        logic          e_rdy;
    } vec_t;

    function automatic vec_t mkv(input logic [PW-1:0] pd, input logic pdv,
                                 input logic [CW-1:0] cz, input logic czv,
                                 input logic e_dv, input logic [CW-1:0] e_d,
                                 input logic e_zv, input logic [PW-1:0] e_z,
                                 input logic e_rdy);
        vec_t v;
        v.pd = pd; v.pdv = pdv; v.cz = cz; v.czv = czv;
        v.e_dv = e_dv; v.e_d = e_d; v.e_zv = e_zv; v.e_z = e_z; v.e_rdy = e_rdy;
        return v;
    endfunction

    localparam logic [CW-1:0] D1 = 40'h01_0030_0801;  // {4,3,2,1}
    localparam logic [CW-1:0] Z1 = 40'h12_3456_789A;

    vec_t          vt[13];
    int            nacc;
    logic [9:0]    rdy_seen;
    logic [CW-1:0] w;

    initial begin
        // Assembly with a 2-cycle gap after beat 2, then one serialised word.
        vt[0]  = mkv(10'd1, 1, '0, 0,  0, '0, 0, 10'h000, 1);
        vt[1]  = mkv(10'd2, 1, '0, 0,  0, '0, 0, 10'h000, 1);
        vt[2]  = mkv(10'd0, 0, '0, 0,  0, '0, 0, 10'h000, 1);
        vt[3]  = mkv(10'd0, 0, '0, 0,  0, '0, 0, 10'h000, 1);
        vt[4]  = mkv(10'd3, 1, '0, 0,  0, '0, 0, 10'h000, 1);
        vt[5]  = mkv(10'd4, 1, '0, 0,  1, D1, 0, 10'h000, 1);
        vt[6]  = mkv(10'd0, 0, '0, 0,  0, D1, 0, 10'h000, 1);
        vt[7]  = mkv(10'd0, 0, Z1, 1,  0, D1, 0, 10'h000, 1);
        vt[8]  = mkv(10'd0, 0, '0, 0,  0, D1, 1, 10'h09A, 1);
        vt[9]  = mkv(10'd0, 0, '0, 0,  0, D1, 1, 10'h19E, 1);
        vt[10] = mkv(10'd0, 0, '0, 0,  0, D1, 1, 10'h345, 1);
        vt[11] = mkv(10'd0, 0, '0, 0,  0, D1, 1, 10'h048, 1);
        vt[12] = mkv(10'd0, 0, '0, 0,  0, D1, 0, 10'h000, 1);

        bus.pin_d = '0; bus.pin_d_vld = 1'b0; bus.loopback = 1'b0;
        bus.core_z = '0; bus.core_z_vld = 1'b0;
        mon_clear();

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_core_d", 64'(bus.core_d), 64'h0);
        check("rst_core_d_vld", 64'(bus.core_d_vld), 64'h0);
        check("rst_pin_z", 64'(bus.pin_z), 64'h0);
        check("rst_pin_z_vld", 64'(bus.pin_z_vld), 64'h0);
        check("rst_lb_ovf", 64'(bus.lb_ovf), 64'h0);
        check("rst_core_z_rdy", 64'(bus.core_z_rdy), 64'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Assembly and serialisation table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.pin_d = vt[i].pd;  bus.pin_d_vld  = vt[i].pdv;
            bus.core_z = vt[i].cz; bus.core_z_vld = vt[i].czv;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_core_d_vld", i), 64'(bus.core_d_vld), 64'(vt[i].e_dv));
            check($sformatf("vec%0d_core_d", i), 64'(bus.core_d), 64'(vt[i].e_d));
            check($sformatf("vec%0d_pin_z_vld", i), 64'(bus.pin_z_vld), 64'(vt[i].e_zv));
            check($sformatf("vec%0d_pin_z", i), 64'(bus.pin_z), 64'(vt[i].e_z));
            check($sformatf("vec%0d_core_z_rdy", i), 64'(bus.core_z_rdy), 64'(vt[i].e_rdy));
        end
        @(negedge clk);
        bus.pin_d_vld = 1'b0; bus.core_z_vld = 1'b0;
        repeat (4) @(negedge clk);

        // Full FIFO with core_z_vld held for 10 cycles
        @(posedge clk); #1;
        mon_clear(); expq.delete();
        nacc = 0; rdy_seen = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.core_z = cw(nacc);
            bus.core_z_vld = 1'b1;
            #1;
            rdy_seen[i] = bus.core_z_rdy;
            if (bus.core_z_rdy) begin
                expq.push_back(cw(nacc));
                nacc++;
            end
        end
        @(negedge clk);
        bus.core_z_vld = 1'b0;
        repeat (40) @(negedge clk);
        check("full_rdy_pattern", 64'(rdy_seen), 64'(10'b0001011111));
        check("full_handshakes", 64'(nacc), 64'd6);
        check_stream("full");

        // Loopback, matched rates: every word comes back unchanged
        @(negedge clk);
        bus.loopback = 1'b1;
        @(posedge clk); #1;
        mon_clear(); expq.delete();
        for (int k = 0; k < 6; k++) begin
            w = lbw(k);
            expq.push_back(w);
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                bus.pin_d = w[b*PW +: PW];
                bus.pin_d_vld = 1'b1;
                if (b == 0) begin
                    #1;
                    check($sformatf("lb_rdy_low%0d", k), 64'(bus.core_z_rdy), 64'h0);
                end
            end
        end
        @(negedge clk);
        bus.pin_d_vld = 1'b0;
        repeat (40) @(negedge clk);
        check_stream("lb");
        check("lb_no_core_d_vld", 64'(mon_dvld), 64'h0);
        check("lb_ovf_clear", 64'(bus.lb_ovf), 64'h0);

        // Loopback overflow: queue is topped up by the core, then loopback
        // is switched on while the serialiser is still busy so the first
        // loopback word meets a full FIFO (matched rates never fill it).
        @(negedge clk);
        bus.loopback = 1'b0;
        @(posedge clk); #1;
        mon_clear(); expq.delete();
        nacc = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (i == 7) bus.loopback = 1'b1;
            bus.core_z_vld = (i <= 6);
            bus.core_z = cw(10 + nacc);
            if (i >= 6 && i < 30) begin
                w = lbw(10 + (i - 6) / 4);
                bus.pin_d = w[((i - 6) % 4)*PW +: PW];
                bus.pin_d_vld = 1'b1;
            end else begin
                bus.pin_d_vld = 1'b0;
            end
            #1;
            if (bus.core_z_vld && bus.core_z_rdy) nacc++;
        end
        @(negedge clk);
        bus.pin_d_vld = 1'b0; bus.core_z_vld = 1'b0;
        for (int k = 0; k < 6; k++) expq.push_back(cw(10 + k));
        for (int k = 1; k < 6; k++) expq.push_back(lbw(10 + k));
        repeat (60) @(negedge clk);
        check("ovf_core_handshakes", 64'(nacc), 64'd6);
        check_stream("ovf");
        check("ovf_flag", 64'(bus.lb_ovf), 64'h1);
        check("ovf_no_core_d_vld", 64'(mon_dvld), 64'h0);
        bus.loopback = 1'b0;
        #1;
        check("ovf_sticky", 64'(bus.lb_ovf), 64'h1);
        check("ovf_rdy_back", 64'(bus.core_z_rdy), 64'h1);

        // Reset during a partial input word and an output word in flight
        @(negedge clk);
        bus.core_z = 40'hFE_DCBA_9876; bus.core_z_vld = 1'b1;
        bus.pin_d = 10'h0AA; bus.pin_d_vld = 1'b1;
        @(negedge clk);
        bus.core_z_vld = 1'b0;
        bus.pin_d = 10'h0BB;
        @(negedge clk);
        bus.pin_d_vld = 1'b0;
        @(negedge clk);
        check("mid_pin_z_vld", 64'(bus.pin_z_vld), 64'h1);
        check("mid_pin_z_beat1", 64'(bus.pin_z), 64'h2A6);
        check("mid_core_d_held", 64'(bus.core_d), 64'(D1));
        #2 rst = 1'b1;
        #1;
        check("arst_pin_z_vld", 64'(bus.pin_z_vld), 64'h0);
        check("arst_pin_z", 64'(bus.pin_z), 64'h0);
        check("arst_core_d", 64'(bus.core_d), 64'h0);
        check("arst_lb_ovf", 64'(bus.lb_ovf), 64'h0);
        check("arst_core_z_rdy", 64'(bus.core_z_rdy), 64'h1);
        mon_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            bus.pin_d = 10'(b + 5);
            bus.pin_d_vld = 1'b1;
        end
        @(posedge clk); #1;
        check("post_rst_core_d_vld", 64'(bus.core_d_vld), 64'h1);
        check("post_rst_core_d", 64'(bus.core_d), 64'h02_0070_1805);
        @(negedge clk);
        bus.pin_d_vld = 1'b0;
        @(posedge clk); #1;
        check("post_rst_strobe_end", 64'(bus.core_d_vld), 64'h0);
        repeat (10) @(negedge clk);
        check("post_rst_no_out_beats", 64'(mon_beats), 64'h0);
        check("post_rst_one_strobe", 64'(mon_dvld), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
